icache_controller: RTL

Direct-mapped instruction cache controller between the CPU fetch port and the 128-bit block instruction memory. It serves 32-bit instruction reads from an 8-entry × 16-byte cache and stalls the CPU through `busywait` on a miss. On a miss it sequences a full-block refill from instruction memory, installs the block, then replays the lookup as a hit.

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_array.sv | 49 ++++
 rtl/icache_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types, widths and address field helpers for the instruction cache.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package icache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int BLOCK_W  = 128;
    localparam int WORD_W   = 32;
    localparam int MADDR_W  = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    // CPU byte address layout: [9:7] tag, [6:4] index, [3:2] word, [1:0] ignored
    function automatic logic [TAG_W-1:0] get_tag(input logic [9:0] addr);
        return addr[9:7];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [9:0] addr);
        return addr[6:4];
    endfunction

    function automatic logic [OFFSET_W-1:0] get_word(input logic [9:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: synchronous block write, combinational lookup and word select.
// Latency: lookup 0 cycles, write visible the cycle after wr_en.
// Backpressure: none; the controller owns all sequencing.
module icache_array
    import icache_pkg::*;
#(
    parameter int BLOCKS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [BLOCK_W-1:0]  wr_data,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [TAG_W-1:0]    rd_tag,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                hit,
    output logic [WORD_W-1:0]   rd_word
);

    logic [BLOCKS-1:0]  valid;
    logic [TAG_W-1:0]   tags  [BLOCKS];
    logic [BLOCK_W-1:0] data  [BLOCKS];

    // Valid bits are the only state cleared by reset; tags and data may hold stale contents
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data install on a refill write
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    // Combinational compare and word select
    always_comb begin
        hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
        rd_word = data[rd_index][rd_offset*WORD_W +: WORD_W];
    end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped I-cache controller; optional hit/miss counters under ICACHE_STATS_EN.
// Latency: hit 0 cycles; miss stalls through MEM_READ (until mem_busywait low) plus one UPDATE cycle.
// Backpressure: busywait stalls the CPU on a miss; mem_busywait holds the FSM in MEM_READ.
module icache_controller
    import icache_pkg::*;
#(
    parameter int BLOCKS = 8,
    parameter int ADDR_W = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                read,
    input  logic [ADDR_W-1:0]   address,
    output logic [WORD_W-1:0]   instruction,
    output logic                busywait,
    output logic                mem_read,
    output logic [MADDR_W-1:0]  mem_address,
    input  logic [BLOCK_W-1:0]  mem_readdata,
`ifdef ICACHE_STATS_EN
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count,
`endif
    input  logic                mem_busywait
);

    state_t              state;
    state_t              next_state;
    logic                arr_hit;
    logic [WORD_W-1:0]   arr_word;
    logic                lookup_hit;
    logic                miss_start;
    logic                fill_en;
    logic [WORD_W-1:0]   last_instr;
    logic [MADDR_W-1:0]  mem_address_q;
    logic                unused_addr_bits;

    // Byte-within-word bits never affect a 32-bit fetch
    assign unused_addr_bits = ^address[1:0];

    icache_array #(.BLOCKS(BLOCKS)) u_array (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (fill_en),
        .wr_index  (mem_address_q[INDEX_W-1:0]),
        .wr_tag    (mem_address_q[MADDR_W-1:INDEX_W]),
        .wr_data   (mem_readdata),
        .rd_index  (get_index(address)),
        .rd_tag    (get_tag(address)),
        .rd_offset (get_word(address)),
        .hit       (arr_hit),
        .rd_word   (arr_word)
    );

    assign lookup_hit  = read && arr_hit;
    assign miss_start  = (state == IDLE) && read && !arr_hit;
    assign mem_address = mem_address_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: memory reacts combinationally to mem_read, so the first MEM_READ
    // cycle is already a full observed cycle before mem_busywait is trusted
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (read && !arr_hit) next_state = MEM_READ;
            MEM_READ: if (!mem_busywait)    next_state = UPDATE;
            UPDATE:                         next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    // Outputs: a reset on the capture edge drops the fill so nothing is installed
    always_comb begin
        mem_read    = (state == MEM_READ);
        busywait    = (state != IDLE) || (read && !arr_hit);
        fill_en     = (state == MEM_READ) && !mem_busywait && !reset;
        instruction = lookup_hit ? arr_word : last_instr;
    end

    // Block address is latched when the miss is accepted and held through the refill
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address_q <= '0;
        end else if (miss_start) begin
            mem_address_q <= {get_tag(address), get_index(address)};
        end
    end

    // Remember the last hit word so instruction holds steady while stalled or idle
    always_ff @(posedge clock) begin
        if (reset) begin
            last_instr <= '0;
        end else if (lookup_hit) begin
            last_instr <= arr_word;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss counters; the post-refill replay counts as a hit
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if ((state == IDLE) && lookup_hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_start && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
